// File: rtl/rf_write_arbiter_pkg.sv
// Shared CPU constants and types for the register-file write path.
package rf_write_arbiter_pkg;

  localparam int unsigned WIDTH    = 64;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned ZR_INDEX = 31;
  localparam int unsigned ADDR_W   = $clog2(NREGS);

  typedef logic [ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_M = 1'b1
  } requester_e;

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; grants are combinational from the requests and
// the last-served requester, and nothing is granted while reset is high.
module rr_arbiter2
  import rf_write_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_m,
  output logic gnt_a,
  output logic gnt_m
);

  requester_e rr_last_q, rr_last_d;

  always_comb begin
    gnt_a     = 1'b0;
    gnt_m     = 1'b0;
    rr_last_d = rr_last_q;
    if (!reset) begin
      // On a tie the requester that was not served last wins.
      if (req_a && (!req_m || rr_last_q == REQ_M)) begin
        gnt_a = 1'b1;
      end else if (req_m) begin
        gnt_m = 1'b1;
      end
    end
    if (gnt_a) begin
      rr_last_d = REQ_A;
    end else if (gnt_m) begin
      rr_last_d = REQ_M;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q <= REQ_M;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU writeback and memory return,
// producing registered one-hot enables, data and address for the register file.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_data,
  output logic              a_ready,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [WIDTH-1:0]  m_data,
  output logic              m_ready,
  output logic [NREGS-1:0]  wr_en,
  output logic [WIDTH-1:0]  wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_busy
);

  logic              transfer;
  reg_addr_t         sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic [NREGS-1:0]  wr_en_q, wr_en_d;
  logic [WIDTH-1:0]  wr_data_q;
  reg_addr_t         wr_addr_q;

  rr_arbiter2 u_rr_arbiter2 (
    .clk   (clk),
    .reset (reset),
    .req_a (a_valid),
    .req_m (m_valid),
    .gnt_a (a_ready),
    .gnt_m (m_ready)
  );

  assign transfer = a_ready | m_ready;
  assign sel_addr = a_ready ? a_addr : m_addr;
  assign sel_data = a_ready ? a_data : m_data;

  // XZR writes are accepted but never raise an enable.
  always_comb begin
    wr_en_d = '0;
    if (transfer && sel_addr != reg_addr_t'(ZR_INDEX)) begin
      wr_en_d[sel_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      if (transfer) begin
        wr_data_q <= sel_data;
        wr_addr_q <= sel_addr;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign wr_addr = wr_addr_q;
  assign wr_busy = |wr_en_q;

  assert property (@(posedge clk) $onehot0(wr_en));
  assert property (@(posedge clk) !(a_ready && m_ready));
  assert property (@(posedge clk) !wr_en[ZR_INDEX]);
  assert property (@(posedge clk) wr_busy == |wr_en);

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two requesters: ALU writeback (A) and load/memory return (M).
- Uses a valid/ready handshake and round-robin arbitration.
- Drives one-hot per-register write enables and a registered write-data bus. These feed the enable and data inputs of the 64-bit enable-gated register instances that make up the register file.
- Sits between the EX/MEM writeback stages and the register file.

Parameters:
- WIDTH, 64, data width of each register.
- NREGS, 32, number of architectural registers; address width is clog2(NREGS).
- ZR_INDEX, 31, register index hardwired to zero (XZR); writes to it are discarded.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- a_valid  input  1  ALU requester has a write pending.
- a_addr  input  5  ALU destination register.
- a_data  input  WIDTH  ALU write data.
- a_ready  output  1  ALU request accepted this cycle.
- m_valid  input  1  memory requester has a write pending.
- m_addr  input  5  memory destination register.
- m_data  input  WIDTH  memory write data.
- m_ready  output  1  memory request accepted this cycle.
- wr_en  output  NREGS  one-hot register enables (registered).
- wr_data  output  WIDTH  write data broadcast to all registers (registered).
- wr_addr  output  5  index of the in-flight write, for forwarding/hazard logic (registered).
- wr_busy  output  1  high when wr_en is nonzero.

Behaviour:
- Single clock, clk. reset is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values (the cycle after reset is sampled high):
  - wr_en=0, wr_data=0, wr_addr=0, wr_busy=0.
  - rr_last=M, so A wins the first tie.
- While reset is high, a_ready=m_ready=0 and nothing is accepted.
- Readies are combinational from the valids and rr_last. At most one ready is high in any cycle.
- Grant rules:
  - Only A valid: grant A.
  - Only M valid: grant M.
  - Both valid: grant the requester not equal to rr_last.
  - Neither valid: no grant.
- Transfer occurs when valid && ready are high in the same cycle.
  - On a transfer, rr_last becomes the granted requester.
  - With no transfer, rr_last holds.
- Latency: a request accepted at edge N produces wr_en[addr]=1, wr_data=data and wr_addr=addr during cycle N..N+1. The register file captures the data at edge N+1.
- wr_en is high for exactly one cycle per accepted transfer. Back-to-back transfers give back-to-back one-cycle pulses; full throughput is one write per cycle.
- ZR_INDEX:
  - The transfer is still accepted, and it still updates rr_last.
  - wr_en stays all-zero, wr_busy=0 and wr_data updates as normal.
- No transfer in a cycle: wr_en returns to 0 on the next edge. wr_data and wr_addr hold their last values.
- Requester obligations: hold valid, addr and data stable until accepted. Dropping valid before acceptance is legal and withdraws the request.
- Same address from both requesters in one cycle: writes are serialized in grant order. The later write determines the final register value. No merging.
- Reset asserted mid-stream: the in-flight wr_en pulse is cleared at the same edge and is not completed. Pending requests are not accepted and must be re-presented after reset.
- Invariants (checked by assertions):
  - $onehot0(wr_en).
  - !(a_ready && m_ready).
  - wr_en[ZR_INDEX] is never set.
  - wr_busy == |wr_en.

Decomposition:
- Shared cpu package:
  - WIDTH, NREGS, ZR_INDEX constants.
  - reg_addr_t typedef (5-bit).
  - requester_e enum {REQ_A, REQ_M}, used for rr_last.
- Sub-module rr_arbiter2: 2-way round-robin grant, holding the rr_last state. It is natural and reusable for the later read-port sharing.
- Address-to-one-hot decode is inline in rf_write_arbiter.

Test Plan:
- Reset sequence: reset=1 for 2 cycles with a_valid=1 → a_ready=0 throughout, and wr_en=0, wr_data=0 after the first edge.
- Single write, A only: a_addr=5, a_data=500 → a_ready=1 that cycle; next cycle wr_en=32'h0000_0020, wr_data=500 for one cycle, then wr_en=0.
- Tie sequence, both valid every cycle with A addr 1 and M addr 2:
  - Grants go A, M, A, M.
  - wr_en is 0x2, 0x4, 0x2, 0x4 on consecutive cycles.
  - Each requester waits at most 1 cycle.
- XZR discard: m_addr=31, m_data=1234 → m_ready=1, then wr_en=0 and wr_busy=0. A following tie grants A.
- Same-address collision: a_addr=m_addr=7, a_data=10, m_data=20, rr_last=M → A is written first, then M; the register-file model shows X7=20.
- Mid-stream reset: accept A addr 3, then assert reset on the next cycle → wr_en clears at that edge and no further grants occur until reset drops.
